// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the fetch (IF) and memory-access (MA) stages.
// One access is outstanding at a time, MA has priority, and an in-flight fetch read can be flushed.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              ma_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_ma
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_RESP, S_WR} state_t;
    typedef enum logic {OWN_IF, OWN_MA} owner_t;

    state_t state, state_nxt;
    owner_t owner;
    logic   flush_pend;
    logic   grant_ma, grant_if, if_drop;

    // Grants are only issued from IDLE, so the RESP->IDLE edge that raises
    // valid can never re-issue a request that is still being held.
    assign grant_ma = (state == S_IDLE) && ma_req;
    assign grant_if = (state == S_IDLE) && !ma_req && if_req;
    assign if_drop  = (owner == OWN_IF) && (flush_pend || if_flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_ma)      state_nxt = ma_we ? S_WR : S_RD;
                else if (grant_if) state_nxt = S_RD;
            end
            S_RD:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            S_WR:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall_if = if_req && !if_valid;
        stall_ma = ma_req && !ma_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_IF;
            flush_pend <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            if_rdata   <= '0;
            ma_rdata   <= '0;
            if_valid   <= 1'b0;
            ma_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block override earlier ones.
            if_valid <= 1'b0;
            ma_valid <= 1'b0;

            if (grant_ma) begin
                owner    <= OWN_MA;
                mem_addr <= ma_addr;
                if (ma_we) begin
                    mem_wdata <= ma_wdata;
                    mem_we    <= 1'b1;
                end
            end else if (grant_if) begin
                owner    <= OWN_IF;
                mem_addr <= if_addr;
            end

            if ((state == S_RD || state == S_RESP) && owner == OWN_IF && if_flush)
                flush_pend <= 1'b1;

            if (state == S_RESP) begin
                flush_pend <= 1'b0;
                if (owner == OWN_MA) begin
                    ma_rdata <= mem_rdata;
                    ma_valid <= 1'b1;
                end else if (!if_drop) begin
                    if_rdata <= mem_rdata;
                    if_valid <= 1'b1;
                end
            end

            if (state == S_WR) begin
                mem_we   <= 1'b0;
                ma_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: synchronous memory model, hand-computed expected values.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, ma_req, ma_we;
    logic [15:0] if_addr, ma_addr, ma_wdata, mem_rdata;
    logic [15:0] if_rdata, ma_rdata, mem_addr, mem_wdata;
    logic        if_valid, ma_valid, mem_we, stall_if, stall_ma;

    logic [15:0] mem_model [0:1023];
    int n_checks = 0;
    int n_fail   = 0;
    int if_pulses = 0, ma_pulses = 0, overlap = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata), .ma_valid(ma_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_ma(stall_ma)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for the address presented appears one cycle later.
    always @(posedge clk) begin
        mem_rdata <= mem_model[mem_addr[9:0]];
        if (mem_we) mem_model[mem_addr[9:0]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (if_valid) if_pulses++;
        if (ma_valid) ma_pulses++;
        if (if_valid && ma_valid) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({tag, " mem_we"},    32'(mem_we),    32'h0);
        check({tag, " if_rdata"},  32'(if_rdata),  32'h0);
        check({tag, " ma_rdata"},  32'(ma_rdata),  32'h0);
        check({tag, " if_valid"},  32'(if_valid),  32'h0);
        check({tag, " ma_valid"},  32'(ma_valid),  32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'(i) ^ 16'h5A00;
        mem_model[10'h010] = 16'hA5A5;
        mem_model[10'h011] = 16'h1111;
        mem_model[10'h300] = 16'h3300;
        mem_model[10'h040] = 16'h4040;
        mem_model[10'h042] = 16'h4242;

        rst_n = 1'b0; if_req = 0; if_flush = 0; ma_req = 0; ma_we = 0;
        if_addr = '0; ma_addr = '0; ma_wdata = '0;
        #1;
        check_all_zero("reset");
        step(); step();
        rst_n = 1'b1;
        step();
        check("reset stall_if", 32'(stall_if), 32'h0);
        check("reset stall_ma", 32'(stall_ma), 32'h0);

        // Plain IF read of 0x0010, then held req with a new address in the valid cycle
        if_req = 1; if_addr = 16'h0010;
        step();
        check("rd1 mem_addr",   32'(mem_addr), 32'h0010);
        check("rd1 stall_if c1", 32'(stall_if), 32'h1);
        check("rd1 if_valid c1", 32'(if_valid), 32'h0);
        step();
        check("rd1 stall_if c2", 32'(stall_if), 32'h1);
        check("rd1 if_valid c2", 32'(if_valid), 32'h0);
        step();
        check("rd1 if_valid c3", 32'(if_valid), 32'h1);
        check("rd1 if_rdata",    32'(if_rdata), 32'hA5A5);
        check("rd1 stall_if c3", 32'(stall_if), 32'h0);
        if_addr = 16'h0011;
        step();
        check("held if_valid off", 32'(if_valid), 32'h0);
        check("held mem_addr",     32'(mem_addr), 32'h0011);
        check("held stall_if",     32'(stall_if), 32'h1);
        step();
        check("held if_valid c2", 32'(if_valid), 32'h0);
        step();
        check("held if_valid c3", 32'(if_valid), 32'h1);
        check("held if_rdata",    32'(if_rdata), 32'h1111);
        if_req = 0;
        step();
        check("held if_valid end", 32'(if_valid), 32'h0);
        check("held mem_addr hold", 32'(mem_addr), 32'h0011);
        check("held ma_valid", 32'(ma_valid), 32'h0);

        // MA write
        ma_req = 1; ma_we = 1; ma_addr = 16'h0200; ma_wdata = 16'h1234;
        #1;
        check("wr stall_ma pre", 32'(stall_ma), 32'h1);
        step();
        check("wr mem_we",    32'(mem_we),    32'h1);
        check("wr mem_addr",  32'(mem_addr),  32'h0200);
        check("wr mem_wdata", 32'(mem_wdata), 32'h1234);
        check("wr ma_valid c1", 32'(ma_valid), 32'h0);
        step();
        check("wr mem_we off", 32'(mem_we),   32'h0);
        check("wr ma_valid",   32'(ma_valid), 32'h1);
        check("wr stall_ma",   32'(stall_ma), 32'h0);
        check("wr if_valid",   32'(if_valid), 32'h0);
        ma_req = 0; ma_we = 0;
        step();
        check("wr ma_valid off", 32'(ma_valid), 32'h0);
        check("wr mem_addr hold", 32'(mem_addr), 32'h0200);
        check("wr mem contents", 32'(mem_model[10'h200]), 32'h1234);

        // Simultaneous IF and MA read requests: MA first
        if_req = 1; if_addr = 16'h0020; ma_req = 1; ma_addr = 16'h0300;
        step();
        check("arb mem_addr ma", 32'(mem_addr), 32'h0300);
        check("arb mem_we",      32'(mem_we),   32'h0);
        step();
        check("arb ma_valid E1", 32'(ma_valid), 32'h0);
        step();
        check("arb ma_valid E2", 32'(ma_valid), 32'h1);
        check("arb ma_rdata",    32'(ma_rdata), 32'h3300);
        check("arb if_valid E2", 32'(if_valid), 32'h0);
        check("arb stall_if E2", 32'(stall_if), 32'h1);
        ma_req = 0;
        step();
        check("arb mem_addr if", 32'(mem_addr), 32'h0020);
        check("arb ma_valid E3", 32'(ma_valid), 32'h0);
        step();
        check("arb if_valid E4", 32'(if_valid), 32'h0);
        step();
        check("arb if_valid E5", 32'(if_valid), 32'h1);
        check("arb if_rdata",    32'(if_rdata), 32'h5A20);
        if_req = 0;
        step();

        // Flush during RD
        if_req = 1; if_addr = 16'h0040;
        step();
        check("flrd mem_addr", 32'(mem_addr), 32'h0040);
        if_flush = 1;
        step();
        if_flush = 0; if_req = 0;
        step();
        check("flrd if_valid", 32'(if_valid), 32'h0);
        check("flrd if_rdata", 32'(if_rdata), 32'h5A20);
        step();
        check("flrd if_valid late", 32'(if_valid), 32'h0);

        // Flush during RESP (sampled on the RESP->IDLE edge)
        if_req = 1; if_addr = 16'h0040;
        step();
        step();
        if_flush = 1;
        step();
        check("flresp if_valid", 32'(if_valid), 32'h0);
        check("flresp if_rdata", 32'(if_rdata), 32'h5A20);
        if_flush = 0; if_req = 0;
        step();
        check("flresp if_valid late", 32'(if_valid), 32'h0);

        // Fetch after flushes completes normally
        if_req = 1; if_addr = 16'h0042;
        step();
        check("post-flush mem_addr", 32'(mem_addr), 32'h0042);
        step();
        step();
        check("post-flush if_valid", 32'(if_valid), 32'h1);
        check("post-flush if_rdata", 32'(if_rdata), 32'h4242);
        if_req = 0;
        step();

        // Flush while MA owns the port has no effect
        ma_req = 1; ma_addr = 16'h0011;
        step();
        if_flush = 1;
        step();
        if_flush = 0;
        step();
        check("maflush ma_valid", 32'(ma_valid), 32'h1);
        check("maflush ma_rdata", 32'(ma_rdata), 32'h1111);
        ma_req = 0;
        step();

        // Reset asserted mid-write
        ma_req = 1; ma_we = 1; ma_addr = 16'h0250; ma_wdata = 16'hBEEF;
        step();
        check("rstwr mem_we pre", 32'(mem_we), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rstwr mem_we async", 32'(mem_we), 32'h0);
        ma_req = 0; ma_we = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        check_all_zero("rstwr after");
        check("rstwr mem untouched", 32'(mem_model[10'h250]), 32'(16'h0250 ^ 16'h5A00));

        // Port works normally after reset, with full read latency
        if_req = 1; if_addr = 16'h0010;
        step();
        check("postrst mem_addr", 32'(mem_addr), 32'h0010);
        step();
        check("postrst if_valid c2", 32'(if_valid), 32'h0);
        step();
        check("postrst if_valid", 32'(if_valid), 32'h1);
        check("postrst if_rdata", 32'(if_rdata), 32'hA5A5);
        if_req = 0;
        step(); step();

        check("if_valid pulse count", 32'(if_pulses), 32'd5);
        check("ma_valid pulse count", 32'(ma_pulses), 32'd3);
        check("valid overlap",        32'(overlap),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
